// File: rtl/enemies_hit_ctrl.sv
// ---------------------------------------------------------------------------
// enemies_hit_ctrl
//   Turns per-pixel overlaps between the enemy layer, the bomb explosion and
//   the player into frame-aligned game events. Collisions seen during a frame
//   are accumulated in sticky pending bits. They are committed on the next
//   startOfFrame, and the resulting pulses appear the cycle after that edge.
//
// Ports
//   clk, resetN     pixel clock, asynchronous active-low reset
//   game_on         level running; a rising edge (re)starts a level
//   startOfFrame    one-cycle pulse at frame start (commit point)
//   enemiesDR_BUS   one-hot enemy drawn at this pixel (bit i = enemy i+1)
//   explosionDR     bomb explosion drawn at this pixel
//   playerDR        player drawn at this pixel
//   enemy_kill      one-cycle kill pulses back to the enemies mux
//   player_hit      one-cycle hit pulse, filtered by invulnerability window
//   score_valid     one-cycle pulse alongside enemy_kill
//   score_delta     points earned by this frame's kills
//   enemies_alive   alive mask
//   level_clear     one-cycle pulse, one cycle after the final enemy_kill
//   kills_total     saturating kill count since reset
// ---------------------------------------------------------------------------

// Per-enemy collision terms. kill_term is the per-pixel hit on a live enemy.
// kill_now is what a frame commit would actually kill.
module enemies_hit_lane (
    input  logic enemy_dr,
    input  logic explosion_dr,
    input  logic alive,
    input  logic pend,
    output logic kill_term,
    output logic kill_now
);
    assign kill_term = enemy_dr & explosion_dr & alive;
    assign kill_now  = pend & alive;
endmodule

module enemies_hit_ctrl #(
    parameter int POINTS_PER_ENEMY = 10,
    parameter int INVULN_FRAMES    = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       game_on,
    input  logic       startOfFrame,
    input  logic [2:0] enemiesDR_BUS,
    input  logic       explosionDR,
    input  logic       playerDR,
    output logic [2:0] enemy_kill,
    output logic       player_hit,
    output logic       score_valid,
    output logic [7:0] score_delta,
    output logic [2:0] enemies_alive,
    output logic       level_clear,
    output logic [7:0] kills_total
);

    localparam int NUM_LANES = 3;

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t state, state_nxt;

    logic                 game_on_d;
    logic                 game_on_rise;
    logic [NUM_LANES-1:0] pend_kill, pend_kill_nxt;
    logic                 pend_hit, pend_hit_nxt;
    logic [7:0]           invuln_cnt, invuln_nxt;
    // Set by the commit that kills the last enemy; it produces level_clear
    // one cycle later so the pulse trails enemy_kill.
    logic                 clear_arm, clear_arm_nxt;

    logic [NUM_LANES-1:0] enemy_kill_nxt;
    logic                 player_hit_nxt;
    logic                 score_valid_nxt;
    logic [7:0]           score_delta_nxt;
    logic [NUM_LANES-1:0] alive_nxt;
    logic                 level_clear_nxt;
    logic [7:0]           kills_nxt;

    logic [NUM_LANES-1:0] kill_term;
    logic [NUM_LANES-1:0] kill_now;
    logic [NUM_LANES-1:0] alive_after;
    logic                 hit_term;
    logic [1:0]           kill_cnt;
    logic [15:0]          points;
    logic [8:0]           kills_sum;

    // -----------------------------------------------------------------------
    // Per-enemy collision terms
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        enemies_hit_lane u_lane (
            .enemy_dr     (enemiesDR_BUS[i]),
            .explosion_dr (explosionDR),
            .alive        (enemies_alive[i]),
            .pend         (pend_kill[i]),
            .kill_term    (kill_term[i]),
            .kill_now     (kill_now[i])
        );
    end

    assign hit_term     = (|enemiesDR_BUS) & playerDR;
    assign game_on_rise = game_on & ~game_on_d;
    assign alive_after  = enemies_alive & ~kill_now;
    assign kill_cnt     = {1'b0, kill_now[0]} + {1'b0, kill_now[1]} + {1'b0, kill_now[2]};
    assign points       = 16'(kill_cnt) * 16'(POINTS_PER_ENEMY);
    assign kills_sum    = {1'b0, kills_total} + 9'(kill_cnt);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state. A low game_on overrides everything, including a
    // commit that lands on the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (!game_on) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (game_on_rise) state_nxt = RUN;
                RUN:     if (startOfFrame && (alive_after == '0)) state_nxt = CLEAR;
                CLEAR:   state_nxt = CLEAR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. This computes the next value of every registered output
    // and of the pending/invulnerability state. Pulses default to 0 so each
    // one lasts exactly one cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        enemy_kill_nxt  = '0;
        player_hit_nxt  = 1'b0;
        score_valid_nxt = 1'b0;
        score_delta_nxt = '0;
        level_clear_nxt = 1'b0;
        clear_arm_nxt   = 1'b0;
        alive_nxt       = enemies_alive;
        kills_nxt       = kills_total;
        pend_kill_nxt   = pend_kill;
        pend_hit_nxt    = pend_hit;
        invuln_nxt      = invuln_cnt;

        if (!game_on) begin
            pend_kill_nxt = '0;
            pend_hit_nxt  = 1'b0;
            invuln_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    pend_kill_nxt = '0;
                    pend_hit_nxt  = 1'b0;
                    invuln_nxt    = '0;
                    if (game_on_rise) alive_nxt = '1;
                end

                RUN: begin
                    if (startOfFrame) begin
                        enemy_kill_nxt = kill_now;
                        alive_nxt      = alive_after;
                        if (kill_now != '0) begin
                            score_valid_nxt = 1'b1;
                            score_delta_nxt = points[7:0];
                            kills_nxt       = kills_sum[8] ? 8'hFF : kills_sum[7:0];
                        end

                        if (pend_hit && (invuln_cnt == '0)) begin
                            player_hit_nxt = 1'b1;
                            invuln_nxt     = 8'(INVULN_FRAMES);
                        end else if (invuln_cnt != '0) begin
                            invuln_nxt = invuln_cnt - 8'd1;
                        end

                        // A collision on the commit cycle belongs to the new
                        // frame, so it reloads the pending bits.
                        pend_kill_nxt = kill_term;
                        pend_hit_nxt  = hit_term;

                        if (alive_after == '0) begin
                            clear_arm_nxt = 1'b1;
                            pend_kill_nxt = '0;
                            pend_hit_nxt  = 1'b0;
                        end
                    end else begin
                        pend_kill_nxt = pend_kill | kill_term;
                        pend_hit_nxt  = pend_hit | hit_term;
                    end
                end

                CLEAR: begin
                    pend_kill_nxt   = '0;
                    pend_hit_nxt    = 1'b0;
                    level_clear_nxt = clear_arm;
                end

                default: begin
                    pend_kill_nxt = '0;
                    pend_hit_nxt  = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            game_on_d     <= 1'b0;
            pend_kill     <= '0;
            pend_hit      <= 1'b0;
            invuln_cnt    <= '0;
            clear_arm     <= 1'b0;
            enemy_kill    <= '0;
            player_hit    <= 1'b0;
            score_valid   <= 1'b0;
            score_delta   <= '0;
            enemies_alive <= '1;
            level_clear   <= 1'b0;
            kills_total   <= '0;
        end else begin
            game_on_d     <= game_on;
            pend_kill     <= pend_kill_nxt;
            pend_hit      <= pend_hit_nxt;
            invuln_cnt    <= invuln_nxt;
            clear_arm     <= clear_arm_nxt;
            enemy_kill    <= enemy_kill_nxt;
            player_hit    <= player_hit_nxt;
            score_valid   <= score_valid_nxt;
            score_delta   <= score_delta_nxt;
            enemies_alive <= alive_nxt;
            level_clear   <= level_clear_nxt;
            kills_total   <= kills_nxt;
        end
    end

endmodule

// File: tb/tb_enemies_hit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enemies_hit_ctrl
//   Drives directed scenarios with literal expectations, then random traffic.
//   A frame-level reference model runs alongside, and its outputs are compared
//   with the DUT on every falling edge outside reset.
// ---------------------------------------------------------------------------
module tb_enemies_hit_ctrl;

    localparam int PTS = 10;
    localparam int INV = 3;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       game_on = 1'b0;
    logic       sof = 1'b0;
    logic [2:0] bus = 3'b000;
    logic       expl = 1'b0;
    logic       pl = 1'b0;

    logic [2:0] enemy_kill;
    logic       player_hit;
    logic       score_valid;
    logic [7:0] score_delta;
    logic [2:0] enemies_alive;
    logic       level_clear;
    logic [7:0] kills_total;

    always #5 clk = ~clk;

    enemies_hit_ctrl #(
        .POINTS_PER_ENEMY (PTS),
        .INVULN_FRAMES    (INV)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .game_on       (game_on),
        .startOfFrame  (sof),
        .enemiesDR_BUS (bus),
        .explosionDR   (expl),
        .playerDR      (pl),
        .enemy_kill    (enemy_kill),
        .player_hit    (player_hit),
        .score_valid   (score_valid),
        .score_delta   (score_delta),
        .enemies_alive (enemies_alive),
        .level_clear   (level_clear),
        .kills_total   (kills_total)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model. mode: 0 = waiting for a level, 1 = playing,
    // 2 = level finished.
    // ---------------------------------------------------------------------
    typedef struct {
        int       mode;
        bit       prev_on;
        bit [2:0] alive;
        bit [2:0] pend;
        bit       phit;
        int       inv;
        bit       clear_next;
        bit [2:0] kill;
        bit       hit;
        bit       sv;
        int       sd;
        bit       lc;
        int       kt;
    } model_t;

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.prev_on = 0; r.alive = 3'b111; r.pend = 0; r.phit = 0;
        r.inv = 0; r.clear_next = 0; r.kill = 0; r.hit = 0; r.sv = 0;
        r.sd = 0; r.lc = 0; r.kt = 0;
        return r;
    endfunction

    function automatic model_t step(model_t m, bit on, bit s, bit [2:0] b, bit e, bit p);
        model_t n = m;
        int c;
        bit [2:0] k;
        n.kill = 0; n.hit = 0; n.sv = 0; n.sd = 0; n.lc = 0;
        n.prev_on = on;
        if (!on) begin
            n.mode = 0; n.pend = 0; n.phit = 0; n.inv = 0; n.clear_next = 0;
        end else if (m.mode == 0) begin
            if (!m.prev_on) begin
                n.mode = 1;
                n.alive = 3'b111;
            end
        end else if (m.mode == 1) begin
            if (s) begin
                k = m.pend & m.alive;
                c = 0;
                for (int i = 0; i < 3; i++) c += int'(k[i]);
                n.kill  = k;
                n.alive = m.alive & ~k;
                if (c != 0) begin
                    n.sv = 1;
                    n.sd = (c * PTS) % 256;
                    n.kt = (m.kt + c > 255) ? 255 : m.kt + c;
                end
                n.hit = m.phit && (m.inv == 0);
                if (n.hit) n.inv = INV;
                else if (m.inv > 0) n.inv = m.inv - 1;
                n.pend = b & {3{e}} & m.alive;
                n.phit = (b != 0) && p;
                if (n.alive == 0) begin
                    n.mode = 2; n.clear_next = 1; n.pend = 0; n.phit = 0;
                end
            end else begin
                n.pend = m.pend | (b & {3{e}} & m.alive);
                n.phit = m.phit | ((b != 0) && p);
            end
        end else begin
            n.lc = m.clear_next;
            n.clear_next = 0;
            n.pend = 0; n.phit = 0;
        end
        return n;
    endfunction

    model_t m;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) m <= model_reset();
        else         m <= step(m, game_on, sof, bus, expl, pl);
    end

    always @(negedge clk) begin
        if (resetN)
            chk("model", {7'b0, enemy_kill, player_hit, score_valid, score_delta,
                          enemies_alive, level_clear, kills_total},
                         {7'b0, m.kill, m.hit, m.sv, 8'(m.sd), m.alive, m.lc, 8'(m.kt)});
    end

    // ---------------------------------------------------------------------
    // Stimulus. Inputs change on the falling edge and are sampled on the
    // next rising edge, so each call leaves the outputs of that edge visible.
    // ---------------------------------------------------------------------
    task automatic cyc(input bit on, input bit s, input bit [2:0] b, input bit e, input bit p);
        game_on = on; sof = s; bus = b; expl = e; pl = p;
        @(negedge clk);
    endtask

    task automatic new_level();
        cyc(0, 0, 3'b000, 0, 0);
        cyc(1, 0, 3'b000, 0, 0);
    endtask

    initial begin
        int r;
        bit [2:0] rb;

        @(negedge clk);
        @(negedge clk);
        chk("reset_during", {enemy_kill, player_hit, score_valid, score_delta, enemies_alive, level_clear, kills_total},
                            {3'b0, 1'b0, 1'b0, 8'd0, 3'b111, 1'b0, 8'd0});
        resetN = 1'b1;

        // Single kill and score
        cyc(1, 0, 3'b000, 0, 0);
        repeat (3) cyc(1, 0, 3'b010, 1, 0);
        cyc(1, 0, 3'b000, 0, 0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("single_kill", enemy_kill, 3'b010);
        chk("single_score", {score_valid, score_delta}, {1'b1, 8'd10});
        chk("single_alive", {enemies_alive, kills_total}, {3'b101, 8'd1});
        cyc(1, 0, 3'b000, 0, 0);
        chk("single_pulse_len", {enemy_kill, score_valid}, {3'b000, 1'b0});

        // Double kill, dead enemy 2 re-exploded, level clear
        cyc(1, 0, 3'b001, 1, 0);
        cyc(1, 0, 3'b010, 1, 0);
        cyc(1, 0, 3'b100, 1, 0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("double_kill", {enemy_kill, score_delta, level_clear}, {3'b101, 8'd20, 1'b0});
        chk("double_alive", {enemies_alive, kills_total}, {3'b000, 8'd3});
        cyc(1, 0, 3'b000, 0, 0);
        chk("level_clear", {level_clear, enemy_kill}, {1'b1, 3'b000});
        cyc(1, 0, 3'b001, 1, 0);
        chk("clear_pulse_len", level_clear, 1'b0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("clear_no_kill", {enemy_kill, score_valid}, {3'b000, 1'b0});
        new_level();
        chk("restart_alive", enemies_alive, 3'b111);

        // Invulnerability: overlap every frame, hits at frames 1 and 5
        for (int f = 1; f <= 6; f++) begin
            cyc(1, 0, 3'b001, 0, 1);
            cyc(1, 1, 3'b000, 0, 0);
            chk($sformatf("invuln_f%0d", f), player_hit, (f == 1 || f == 5) ? 1'b1 : 1'b0);
        end

        // Abort mid-frame, then abort on the SOF cycle
        cyc(1, 0, 3'b010, 1, 0);
        cyc(0, 0, 3'b000, 0, 0);
        cyc(1, 0, 3'b000, 0, 0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("abort_mid", enemy_kill, 3'b000);
        cyc(1, 0, 3'b100, 1, 0);
        cyc(0, 1, 3'b000, 0, 0);
        chk("abort_sof", {enemy_kill, enemies_alive}, {3'b000, 3'b111});
        cyc(1, 0, 3'b000, 0, 0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("abort_sof_after", enemy_kill, 3'b000);

        // Asynchronous reset mid-level
        cyc(1, 0, 3'b001, 1, 0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("pre_reset_alive", enemies_alive, 3'b110);
        resetN = 1'b0;
        #2;
        chk("async_reset", {enemy_kill, player_hit, score_valid, score_delta, enemies_alive, level_clear, kills_total},
                           {3'b0, 1'b0, 1'b0, 8'd0, 3'b111, 1'b0, 8'd0});
        @(negedge clk);
        resetN = 1'b1;

        // Saturation of kills_total: 86 levels x 3 kills from 0
        for (int l = 0; l < 86; l++) begin
            new_level();
            cyc(1, 0, 3'b001, 1, 0);
            cyc(1, 0, 3'b010, 1, 0);
            cyc(1, 0, 3'b100, 1, 0);
            cyc(1, 1, 3'b000, 0, 0);
            if (l == 84) chk("kills_255", kills_total, 8'd255);
        end
        chk("kills_sat", {kills_total, score_delta}, {8'd255, 8'd30});

        // Explosion only on the SOF cycle counts for the following frame
        new_level();
        cyc(1, 1, 3'b010, 1, 0);
        chk("sof_collision_now", enemy_kill, 3'b000);
        cyc(1, 0, 3'b000, 0, 0);
        cyc(1, 0, 3'b000, 0, 0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("sof_collision_next", enemy_kill, 3'b010);

        // Random traffic, checked by the model on every cycle
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 5));
            rb = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : (r == 2) ? 3'b100 : 3'b000;
            cyc($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0, rb,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
